// File: rtl/seg_driver.sv
// seg_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows a 16-bit value as four hex digits, scanning one digit at a time.
//
// Parameters:
//   REFRESH_DIV         clock cycles each digit stays selected (>= 2)
//   BLANK_LEADING_ZEROS 1 = dark digits above the most significant non-zero nibble
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset, outputs dark while low
//   bin       in   [15:0] value to display, nibble 0 on the rightmost digit
//   segments  out  [7:0] active-low segment drives {dp,g,f,e,d,c,b,a}
//   digit     out  [3:0] active-low one-hot digit enable, digit[i] shows nibble i
module seg_driver #(
  parameter int REFRESH_DIV         = 50000,
  parameter int BLANK_LEADING_ZEROS = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] bin,
  output logic [7:0]  segments,
  output logic [3:0]  digit
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;
  logic [1:0]    index;
  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic          upper_zero;
  logic          blank;
  logic [7:0]    seg_next;
  logic [3:0]    digit_next;

  // Nibble select and leading-zero detection for the digit being scanned.
  // upper_zero is true when this nibble and every nibble above it are zero;
  // digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    nibble     = bin[3:0];
    upper_zero = 1'b0;
    case (index)
      2'd0: begin
        nibble     = bin[3:0];
        upper_zero = 1'b0;
      end
      2'd1: begin
        nibble     = bin[7:4];
        upper_zero = (bin[15:4] == 12'h000);
      end
      2'd2: begin
        nibble     = bin[11:8];
        upper_zero = (bin[15:8] == 8'h00);
      end
      default: begin
        nibble     = bin[15:12];
        upper_zero = (bin[15:12] == 4'h0);
      end
    endcase
    blank = upper_zero && (BLANK_LEADING_ZEROS != 0);
  end

  // Hex to active-high gfedcba pattern.
  always_comb begin
    pattern = 7'h00;
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
  end

  // Segments are inverted for the common-anode board; dp is held off.
  always_comb begin
    seg_next   = blank ? 8'hFF : {1'b1, ~pattern};
    digit_next = ~(4'b0001 << index);
  end

  // Prescaler, scan index and output registers. digit and segments load on
  // the same edge from the pre-edge index, so a digit never shows a
  // neighbour's pattern.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      index    <= 2'd0;
      segments <= 8'hFF;
      digit    <= 4'hF;
    end else begin
      if (count == LAST_COUNT) begin
        count <= '0;
        index <= index + 2'd1;
      end else begin
        count <= count + CW'(1);
      end
      segments <= seg_next;
      digit    <= digit_next;
    end
  end

endmodule

// File: tb/tb_seg_driver.sv
// tb_seg_driver
// Self-checking bench for seg_driver with REFRESH_DIV=4. Two instances share
// clock, reset and bin: one without and one with leading-zero blanking.
// Expected outputs come from a model based on elapsed cycles since reset
// release and the hex table.
module tb_seg_driver;

  localparam int DIV = 4;

  logic        clock;
  logic        reset_n;
  logic [15:0] bin;
  logic [7:0]  segments;
  logic [3:0]  digit;
  logic [7:0]  segments_b;
  logic [3:0]  digit_b;

  int compared;
  int mismatched;

  // Edges since reset release and the bin value seen at the latest edge.
  int          edges;
  logic [15:0] last_bin;

  logic [6:0] enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING_ZEROS(0)) dut (
    .clock(clock), .reset_n(reset_n), .bin(bin),
    .segments(segments), .digit(digit)
  );

  seg_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING_ZEROS(1)) dut_blank (
    .clock(clock), .reset_n(reset_n), .bin(bin),
    .segments(segments_b), .digit(digit_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Time base for the model.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edges    <= 0;
      last_bin <= 16'h0;
    end else begin
      edges    <= edges + 1;
      last_bin <= bin;
    end
  end

  function automatic int model_index();
    return ((edges - 1) / DIV) % 4;
  endfunction

  function automatic logic [3:0] model_digit();
    if (edges == 0) return 4'hF;
    return ~(4'b0001 << model_index());
  endfunction

  function automatic logic [7:0] model_seg(input bit blank_en);
    int idx;
    int nib;
    if (edges == 0) return 8'hFF;
    idx = model_index();
    nib = (int'(last_bin) >> (4 * idx)) & 15;
    if (blank_en && idx > 0 && (int'(last_bin) >> (4 * idx)) == 0) return 8'hFF;
    return {1'b1, ~enc[nib]};
  endfunction

  task automatic test_reset();
    bin = 16'h1234;
    #3 reset_n = 1'b0;
    #1;
    compared++;
    if (digit !== 4'hF || segments !== 8'hFF || digit_b !== 4'hF || segments_b !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL reset_async: digit=%h seg=%h digit_b=%h seg_b=%h, expected F/FF", digit, segments, digit_b, segments_b);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      compared++;
      if (digit !== 4'hF || segments !== 8'hFF || digit_b !== 4'hF || segments_b !== 8'hFF) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cyc %0d: digit=%h seg=%h digit_b=%h seg_b=%h, expected F/FF", i, digit, segments, digit_b, segments_b);
      end
    end
  endtask

  task automatic test_single_value();
    @(negedge clock);
    bin = 16'd10;
    reset_n = 1'b1;
    @(posedge clock); #1;
    compared++;
    if (digit !== 4'b1110 || segments !== 8'h88) begin
      mismatched++;
      $display("[TB] FAIL first_edge: digit=%b seg=%h, expected 1110/88", digit, segments);
    end
    for (int i = 1; i < 4 * DIV + 4; i++) begin
      @(posedge clock); #1;
      compared++;
      if (digit !== model_digit() || segments !== model_seg(1'b0)) begin
        mismatched++;
        $display("[TB] FAIL single cyc %0d: digit=%b seg=%h, expected %b/%h", i, digit, segments, model_digit(), model_seg(1'b0));
      end
    end
  endtask

  task automatic test_hex_sweep();
    logic [15:0] vals [2] = '{16'h1234, 16'hCDEF};
    for (int v = 0; v < 2; v++) begin
      @(negedge clock);
      bin = vals[v];
      for (int i = 0; i < 8 * DIV; i++) begin
        @(posedge clock); #1;
        compared++;
        if (digit !== model_digit() || segments !== model_seg(1'b0)) begin
          mismatched++;
          $display("[TB] FAIL sweep %h cyc %0d: digit=%b seg=%h, expected %b/%h", vals[v], i, digit, segments, model_digit(), model_seg(1'b0));
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [8] = '{16'h000A, 16'h0000, 16'h0100, 16'h1000,
                              16'h00F0, 16'h0001, 16'h0000, 16'h0000};
    vals[6] = 16'($urandom_range(0, 255));
    vals[7] = 16'($urandom);
    for (int v = 0; v < 8; v++) begin
      @(negedge clock);
      bin = vals[v];
      for (int i = 0; i < 5 * DIV; i++) begin
        @(posedge clock); #1;
        compared++;
        if (digit_b !== model_digit() || segments_b !== model_seg(1'b1)) begin
          mismatched++;
          $display("[TB] FAIL blank %h cyc %0d: digit=%b seg=%h, expected %b/%h", vals[v], i, digit_b, segments_b, model_digit(), model_seg(1'b1));
        end
        compared++;
        if (digit !== model_digit() || segments !== model_seg(1'b0)) begin
          mismatched++;
          $display("[TB] FAIL noblank %h cyc %0d: digit=%b seg=%h, expected %b/%h", vals[v], i, digit, segments, model_digit(), model_seg(1'b0));
        end
      end
    end
  endtask

  task automatic test_live_update();
    logic [15:0] nv;
    int budget;
    budget = 0;
    // Align to the first cycle of a digit-0 window.
    while (!(edges > 0 && ((edges - 1) % (4 * DIV)) == 0) && budget < 8 * DIV) begin
      @(posedge clock); #1;
      budget++;
    end
    compared++;
    if (budget >= 8 * DIV) begin
      mismatched++;
      $display("[TB] FAIL live_align: budget=%0d, expected < %0d", budget, 8 * DIV);
    end
    @(negedge clock);
    nv = 16'($urandom);
    nv[3:0] = bin[3:0] ^ 4'h5;
    bin = nv;
    @(posedge clock); #1;
    compared++;
    if (digit !== 4'b1110 || segments !== {1'b1, ~enc[nv[3:0]]}) begin
      mismatched++;
      $display("[TB] FAIL live_next_edge: digit=%b seg=%h, expected 1110/%h", digit, segments, {1'b1, ~enc[nv[3:0]]});
    end
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) begin
        @(negedge clock);
        bin = 16'($urandom);
      end
      @(posedge clock); #1;
      compared++;
      if (digit !== model_digit() || segments !== model_seg(1'b0) ||
          digit_b !== model_digit() || segments_b !== model_seg(1'b1)) begin
        mismatched++;
        $display("[TB] FAIL live cyc %0d: digit=%b seg=%h seg_b=%h, expected %b/%h/%h", i, digit, segments, segments_b, model_digit(), model_seg(1'b0), model_seg(1'b1));
      end
    end
  endtask

  task automatic test_midscan_reset();
    int budget;
    int cnt0;
    budget = 0;
    cnt0 = 0;
    while (!(edges > 0 && model_index() == 2) && budget < 8 * DIV) begin
      @(posedge clock); #1;
      budget++;
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    compared++;
    if (digit !== 4'hF || segments !== 8'hFF || digit_b !== 4'hF || segments_b !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL midscan_dark: digit=%h seg=%h, expected F/FF", digit, segments);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      compared++;
      if (digit !== 4'hF || segments !== 8'hFF) begin
        mismatched++;
        $display("[TB] FAIL midscan_hold cyc %0d: digit=%h seg=%h, expected F/FF", i, digit, segments);
      end
    end
    @(negedge clock);
    bin = 16'($urandom);
    reset_n = 1'b1;
    for (int i = 1; i <= 4 * DIV + 2; i++) begin
      @(posedge clock); #1;
      if (i <= DIV + 1 && digit === 4'b1110) cnt0++;
      compared++;
      if (digit !== model_digit() || segments !== model_seg(1'b0)) begin
        mismatched++;
        $display("[TB] FAIL restart cyc %0d: digit=%b seg=%h, expected %b/%h", i, digit, segments, model_digit(), model_seg(1'b0));
      end
    end
    compared++;
    if (cnt0 !== DIV) begin
      mismatched++;
      $display("[TB] FAIL restart_period: digit0 cycles=%0d, expected %0d", cnt0, DIV);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b1;
    bin        = 16'h0;
    test_reset();
    test_single_value();
    test_hex_sweep();
    test_blanking();
    test_live_update();
    test_midscan_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
